// File: rtl/systolic_result_drain_pkg.sv
// rtl/systolic_result_drain_pkg.sv - shared array-level definitions for the result drain
package systolic_result_drain_pkg;

   localparam int DATA_W_DEFAULT = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

   // Index width for an N-wide dimension; a 1-wide dimension still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// rtl/systolic_result_drain_if.sv - element stream from the drain to its sink
interface systolic_result_drain_if
   import systolic_result_drain_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = DATA_W_DEFAULT
);
   localparam int IDX_W = idx_w(N);

   logic [DATA_W-1:0] o_data;
   logic [IDX_W-1:0]  o_row;
   logic [IDX_W-1:0]  o_col;
   logic              o_valid;
   logic              o_last;
   logic              i_ready;

   modport master (
      output o_data, o_row, o_col, o_valid, o_last,
      input  i_ready
   );

   modport slave (
      input  o_data, o_row, o_col, o_valid, o_last,
      output i_ready
   );
endinterface

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - captures an N x N result matrix on the valid pulse
// and streams it out row-major over a valid/ready handshake.
module systolic_result_drain
   import systolic_result_drain_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                              i_clk,
   input  logic                              i_arst,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]   i_c,
   input  logic                              i_validResult,
   systolic_result_drain_if.master           stream,
   output logic                              o_busy,
   output logic                              o_overflow,
   input  logic                              i_clearOverflow
);
   localparam int               IDX_W    = idx_w(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef logic [N-1:0][N-1:0][DATA_W-1:0] matrix_t;

   drain_state_e     state_q, state_d;
   matrix_t          buf_q;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic             ovf_q, ovf_d;
   logic             capture;
   logic             draining;
   logic             at_last;
   logic             xfer;

   assign draining = (state_q == DRAIN);
   assign at_last  = draining && (row_q == LAST_IDX) && (col_q == LAST_IDX);
   assign xfer     = draining && stream.i_ready;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      ovf_d   = ovf_q;
      capture = 1'b0;

      // Clear first so that a coincident drop below overrides it.
      if (i_clearOverflow) begin
         ovf_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (i_validResult) begin
               capture = 1'b1;
               row_d   = '0;
               col_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && at_last) begin
               row_d = '0;
               col_d = '0;
               if (i_validResult) begin
                  capture = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) begin
                  if (col_q == LAST_IDX) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
               // The buffer is still being read, so this matrix is lost.
               if (i_validResult) begin
                  ovf_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         ovf_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ovf_q   <= ovf_d;
         if (capture) begin
            buf_q <= i_c;
         end
      end
   end

   generate
      if (N == 1) begin : g_single
         assign stream.o_data = buf_q[0][0];
      end else begin : g_multi
         assign stream.o_data = buf_q[row_q][col_q];
      end
   endgenerate

   assign stream.o_row   = row_q;
   assign stream.o_col   = col_q;
   assign stream.o_valid = draining;
   assign stream.o_last  = at_last;
   assign o_busy         = draining;
   assign o_overflow     = ovf_q;

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Downstream consumer of the systolic array top level. It captures the full N x N matrix of 32-bit results on the single-cycle result-valid pulse. It then streams the elements out one per transfer, in row-major order, over a valid/ready interface. This decouples the array from a slower sink such as a bus bridge or DMA.

Parameters:
N, 4, matrix dimension; must match the array instance; legal range 1..16.
DATA_W, 32, width of each result element.

Ports:
i_clk  in  1  clock.
i_arst  in  1  reset, asynchronous, active-high.
i_c  in  [N-1:0][N-1:0][DATA_W-1:0]  result matrix from the array; i_c[r][c] is row r, column c.
i_validResult  in  1  single-cycle pulse; i_c is valid in this cycle.
o_data  out  DATA_W  current element.
o_row  out  IDX_W  row index of o_data.
o_col  out  IDX_W  column index of o_data.
o_valid  out  1  o_data, o_row, o_col and o_last are valid.
i_ready  in  1  sink accepts the element; a transfer occurs when o_valid && i_ready.
o_last  out  1  current element is [N-1][N-1].
o_busy  out  1  drain in progress; equals o_valid.
o_overflow  out  1  sticky flag: a result pulse was dropped.
i_clearOverflow  in  1  synchronous clear of o_overflow.

Behaviour:
- IDX_W = (N > 1) ? $clog2(N) : 1.
- Reset: state IDLE, capture buffer = 0, row/col counters = 0, o_valid = 0, o_last = 0, o_overflow = 0. o_data/o_row/o_col read as 0.
- Reset asserted mid-drain aborts the drain immediately. Buffered data is lost, with no partial flag.
- States:
  - IDLE: o_valid = 0.
  - DRAIN: o_valid = 1.
- IDLE -> DRAIN on the clock edge where i_validResult = 1. That edge registers i_c into the buffer and zeroes both counters.
- Capture latency: the first element [0][0] appears with o_valid = 1 in the cycle after the pulse.
- Output path: o_data = buffer[row][col], o_row = row counter, o_col = col counter. All are driven from registers or the buffer mux; there is no combinational path from i_c to the outputs.
- Hold rule: while o_valid && !i_ready, o_data, o_row, o_col and o_last hold stable.
- On each transfer:
  - col increments.
  - When col == N-1, col wraps to 0 and row increments.
- o_last = (row == N-1) && (col == N-1) while in DRAIN.
- Transfer with o_last = 1:
  - If i_validResult = 0 in the same cycle: -> IDLE.
  - If i_validResult = 1 in the same cycle: capture the new i_c, zero the counters, stay in DRAIN. There is no bubble; [0][0] of the new matrix follows next cycle.
- i_validResult in DRAIN other than on the final transfer: the pulse is dropped, the buffer is unchanged, and o_overflow <= 1.
- i_validResult in IDLE never sets o_overflow.
- o_overflow: i_clearOverflow = 1 clears it next edge. If a set and a clear coincide, the set wins.
- Throughput: with i_ready held high, one matrix drains in exactly N*N cycles. o_valid is high for N*N consecutive cycles.
- N = 1: a single element with o_last = 1. Row/col stay 0.

Decomposition:
- Shared package (alongside other array-level definitions):
  - DATA_W default constant.
  - Drain state enum {IDLE, DRAIN}.
  - IDX_W function of N.
- Single module. The row/col counter pair is small enough to stay inline; no sub-module.

Test Plan:
- Basic drain: pulse with i_c[r][c] = 16*r + c, i_ready = 1 -> o_valid high cycles 1..16 after the pulse. o_data sequence 0,1,2,3,16,17,...,51. o_last only on 51. Then IDLE.
- Backpressure: same matrix, i_ready low for 3 cycles while [1][2] = 18 is presented -> o_data = 18, o_row = 1, o_col = 2 held for all 3 cycles. Sequence intact; total 19 valid cycles.
- Back-to-back: second pulse (all elements 0xDEADBEEF) coincident with the final transfer of the first matrix -> next cycle o_data = 0xDEADBEEF at [0][0], o_valid never drops, o_overflow stays 0.
- Overflow: second pulse while [0][3] is presented -> o_overflow = 1 next cycle. The first matrix finishes unchanged. i_clearOverflow then returns it to 0. A pulse coincident with the clear leaves it at 1.
- Reset mid-drain: assert i_arst at element [2][1] -> o_valid, o_last and o_overflow go 0 immediately. After release, a new pulse drains from [0][0].
- N = 1 build: pulse with value 7 -> one cycle o_valid = 1, o_data = 7, o_last = 1, o_row = o_col = 0.
